layer_buffer_dp: RTL

Parametrised dual-port local feature-map buffer for the per-layer data SRAMs in LocalBuffer. It provides two independent request ports (A and B) with registered 1-cycle reads and defined same-address collision semantics: forwarding for read/write collisions, and a one-entry hold register that serialises write/write collisions. It also has a background clear engine that fills every word with a constant before an accumulating layer starts. It replaces the fixed 144×128 per-layer wrappers with one block configurable per layer.

---
 rtl/layer_buffer_dp.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/layer_buffer_dp.sv
// Dual-port per-layer feature-map buffer.
// Collision forwarding, write/write hold slot, background clear.
module layer_buffer_dp #(
  parameter int                DATA_W    = 128,
  parameter int                DEPTH     = 144,
  parameter int                ADDR_W    = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              addr_err,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic              err_q, err_d;

  logic              a_acc, b_acc, a_ok, b_ok;
  logic              a_wr, b_wr, ww, hold_hit;
  logic              w0_en, w1_en;
  logic [ADDR_W-1:0] w0_addr, w1_addr;
  logic [DATA_W-1:0] w0_data, w1_data;

  assign clear_busy = (state_q != IDLE);
  assign a_ready    = !clear_busy;
  assign b_ready    = !clear_busy && !hold_valid_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign addr_err   = err_q;
  assign clear_done = done_q;

  // Port decode, collision resolution, write-port muxing and read data.
  always_comb begin
    a_acc    = a_req && a_ready;
    b_acc    = b_req && b_ready;
    a_ok     = 32'(a_addr) < DEPTH;
    b_ok     = 32'(b_addr) < DEPTH;
    a_wr     = a_acc && a_we && a_ok;
    b_wr     = b_acc && b_we && b_ok;
    ww       = a_wr && b_wr && (a_addr == b_addr);
    hold_hit = hold_valid_q && a_wr && (a_addr == hold_addr_q);

    w0_en   = a_wr;
    w0_addr = a_addr;
    w0_data = a_wdata;
    w1_en   = 1'b0;
    w1_addr = b_addr;
    w1_data = b_wdata;
    if (state_q == CLEAR) begin
      w1_en   = 1'b1;
      w1_addr = cnt_q;
      w1_data = CLEAR_VAL;
    end else if (hold_valid_q && !hold_hit) begin
      w1_en   = 1'b1;
      w1_addr = hold_addr_q;
      w1_data = hold_data_q;
    end else if (b_wr && !ww) begin
      w1_en   = 1'b1;
    end

    hold_valid_d = ww;
    hold_addr_d  = ww ? b_addr : hold_addr_q;
    hold_data_d  = ww ? b_wdata : hold_data_q;

    a_rvalid_d = a_acc && !a_we;
    b_rvalid_d = b_acc && !b_we;
    err_d      = (a_acc && !a_ok) || (b_acc && !b_ok);

    a_rdata_d = a_rdata_q;
    if (a_rvalid_d) begin
      if (!a_ok)
        a_rdata_d = '0;
      else if (b_wr && b_addr == a_addr)
        a_rdata_d = b_wdata;
      else if (hold_valid_q && hold_addr_q == a_addr)
        a_rdata_d = hold_data_q;
      else
        a_rdata_d = mem[a_addr];
    end

    b_rdata_d = b_rdata_q;
    if (b_rvalid_d) begin
      if (!b_ok)
        b_rdata_d = '0;
      else if (a_wr && a_addr == b_addr)
        b_rdata_d = a_wdata;
      else
        b_rdata_d = mem[b_addr];
    end
  end

  // Clear sequencer: drain any hold visible now or created this cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = (hold_valid_q || ww) ? DRAIN : CLEAR;
          cnt_d   = '0;
        end
      end
      DRAIN: state_d = CLEAR;
      CLEAR: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      err_q        <= err_d;
    end
  end

  // Storage: two write ports, frozen while reset is asserted.
  always_ff @(posedge CK) begin
    if (!RST) begin
      if (w0_en) mem[w0_addr] <= w0_data;
      if (w1_en) mem[w1_addr] <= w1_data;
    end
  end

endmodule
